mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single block-wide data-memory interface between two caches, port 0 (instruction cache) and port 1 (data cache). It sits between the caches' memory-side ports and the memory model. It presents each cache with the same read/write/done handshake the cache already drives toward memory, and serialises their block transfers. Only one memory transaction is outstanding at any time.

## Interface
Parameters:
- c_line_size, 32, word width in bits
- c_block_size, 2, log2 of words per block; block width BW = 2**c_block_size*c_line_size (128)
- address_size, 32, byte address width; block address width AW = address_size - c_block_size - 2 (28)

Ports (p = 0, 1):
- clk_i  in  1  single clock, all state on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- p{p}_read_i  in  1  block read request from cache p
- p{p}_wr_i  in  1  block write-back request from cache p
- p{p}_address_i  in  AW  block address
- p{p}_write_data_i  in  BW  write-back block
- p{p}_busywait_o  out  1  port p waiting on arbiter/memory
- p{p}_read_data_o  out  BW  registered read block
- p{p}_read_done_o  out  1  one-cycle read completion
- p{p}_write_done_o  out  1  one-cycle write completion
- m_read_o  out  1  memory read strobe
- m_wr_o  out  1  memory write strobe
- m_address_o  out  AW  memory block address
- m_write_data_o  out  BW  memory write block
- m_busywait_i  in  1  memory busy
- m_read_data_i  in  BW  memory read block
- m_read_done_i  in  1  memory read complete
- m_write_done_i  in  1  memory write complete

## Operation
- States: IDLE, BUSY, DONE (3-bit encoding, spare codes decode to IDLE).
- IDLE: a port is requesting if read_i | wr_i. If any port is requesting, register grant (1 bit), op (wr_i wins if both set on the granted port), address and write data from the granted port, then go to BUSY. Otherwise stay in IDLE.
- BUSY:
  - m_read_o = op==RD && !m_read_done_i.
  - m_wr_o = op==WR && !m_write_done_i.
  - m_address_o and m_write_data_o come from the latched registers and are stable for the whole transaction.
  - On (!m_busywait_i && matching done): capture m_read_data_i into the granted port's read_data register (reads only), then go to DONE.
- DONE: assert the granted port's read_done_o or write_done_o for exactly one cycle, then go to IDLE. The other port's outputs are unaffected.
- busywait_o[p] = (read_i|wr_i) && !(state==DONE && grant==p).
- If a requester drops its request in BUSY, the memory transaction still completes. The done pulse is still issued and the data register is still updated.
- read_data_o registers hold their last value until the next read completes on that port.
- Reset (asynchronous, mid-transaction included): state=IDLE, all strobes, done and busywait outputs 0, read_data_o=0, address/data registers 0, last_grant=1 (so port 0 wins first under round-robin). Memory strobes drop in the same cycle reset asserts.

## Timing
- Request sampled in IDLE at edge 0. Strobe high from cycle 1.
- Memory done at cycle k → port done pulse and valid read_data_o in cycle k+1 → IDLE in cycle k+2. Next grant is registered at edge k+2.
- Minimum request-to-done latency is 2 cycles (memory done in first BUSY cycle).
- A losing port waits at least one full transaction plus one IDLE cycle.
- Done pulse and read data are coincident, so a cache latching data on done-high samples valid data.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. When both ports request in IDLE, the port ≠ last_grant wins, and last_grant updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, port 1 (data cache) always wins ties. The last_grant register is not built.

## Structure
- mem_arb_pkg holds:
  - state encodings IDLE/BUSY/DONE
  - op encodings RD/WR
  - width functions for BW and AW
- One sub-module: mem_arb_pick, a combinational 2-way picker (req[1:0], last_grant → grant, valid) containing the MEM_ARB_RR_EN choice.

## Test plan
- Reset mid-BUSY (p0 read in flight): reset_ni low → m_read_o=0 same cycle. After release, state IDLE and all outputs 0.
- Single p0 read of address 0x0000010, memory done after 3 BUSY cycles with data 0xDEADBEEF_…_0001 → p0_read_done_o one pulse in cycle 5 with p0_read_data_o equal to that data. p1 outputs stay 0.
- Single p1 write-back of 0xA5A5…A5 to 0x0000020 → m_wr_o high until m_write_done_i, m_write_data_o exact. p1_write_done_o is one pulse, p1_read_data_o unchanged.
- Both ports request at the same edge, RR build: p0 served first, then p1. Repeating the collision serves p1 first. Fixed-priority build: p1 served first both times.
- p0 holds read_i and wr_i together → write performed. p0 drops read_i in BUSY → transaction completes and the done pulse still fires.
- m_busywait_i held high while m_read_done_i is high → no completion until busywait drops. Done is then registered one cycle later.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and width helpers for the two-port cache/memory arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      BUSY = 3'd1,
      DONE = 3'd2
   } state_e;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } op_e;

   // Block width in bits: 2**block_log2 words of line_size bits each.
   function automatic int unsigned block_width(input int unsigned line_size,
                                               input int unsigned block_log2);
      return (32'd1 << block_log2) * line_size;
   endfunction

   // Block address width: byte address minus word-in-block and byte-in-word bits.
   function automatic int unsigned addr_width(input int unsigned addr_size,
                                              input int unsigned block_log2);
      return addr_size - block_log2 - 32'd2;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way request picker.
// Policy selected by MEM_ARB_RR_EN: round-robin when defined, port 1 priority otherwise.
module mem_arb_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       valid
);

   assign valid = |req;

`ifdef MEM_ARB_RR_EN
   // On a tie the port that was not granted last time wins.
   assign grant = (&req) ? ~last_grant : req[1];
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant             = req[1];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-cache (port 0) and data-cache (port 1) block transfers
// onto one memory interface. MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int unsigned c_line_size  = 32,
   parameter  int unsigned c_block_size = 2,
   parameter  int unsigned address_size = 32,
   localparam int unsigned block_w      = block_width(c_line_size, c_block_size),
   localparam int unsigned addr_w       = addr_width(address_size, c_block_size)
) (
   input  logic               clk_i,
   input  logic               reset_ni,

   input  logic               p0_read_i,
   input  logic               p0_wr_i,
   input  logic [addr_w-1:0]  p0_address_i,
   input  logic [block_w-1:0] p0_write_data_i,
   output logic               p0_busywait_o,
   output logic [block_w-1:0] p0_read_data_o,
   output logic               p0_read_done_o,
   output logic               p0_write_done_o,

   input  logic               p1_read_i,
   input  logic               p1_wr_i,
   input  logic [addr_w-1:0]  p1_address_i,
   input  logic [block_w-1:0] p1_write_data_i,
   output logic               p1_busywait_o,
   output logic [block_w-1:0] p1_read_data_o,
   output logic               p1_read_done_o,
   output logic               p1_write_done_o,

   output logic               m_read_o,
   output logic               m_wr_o,
   output logic [addr_w-1:0]  m_address_o,
   output logic [block_w-1:0] m_write_data_o,
   input  logic               m_busywait_i,
   input  logic [block_w-1:0] m_read_data_i,
   input  logic               m_read_done_i,
   input  logic               m_write_done_i
);

   state_e              state_q;
   op_e                 op_q;
   logic                grant_q;
   logic [addr_w-1:0]   addr_q;
   logic [block_w-1:0]  wdata_q;
   logic                last_grant_c;
   logic                pick_grant_c;
   logic                pick_valid_c;
   logic                mem_done_c;
   logic [1:0]          req_c;

   assign req_c = {p1_read_i | p1_wr_i, p0_read_i | p0_wr_i};

`ifdef MEM_ARB_RR_EN
   logic last_grant_q;
   assign last_grant_c = last_grant_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_grant_q <= 1'b1;
      end else if (state_q == IDLE && pick_valid_c) begin
         last_grant_q <= pick_grant_c;
      end
   end
`else
   assign last_grant_c = 1'b1;
`endif

   mem_arb_pick u_pick (
      .req        (req_c),
      .last_grant (last_grant_c),
      .grant      (pick_grant_c),
      .valid      (pick_valid_c)
   );

   // Memory completion for the latched op; busywait masks a done that arrives early.
   assign mem_done_c = !m_busywait_i &&
                       ((op_q == WR) ? m_write_done_i : m_read_done_i);

   // Arbiter FSM with registered grant, transaction latches, read data and done pulses.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q         <= IDLE;
         op_q            <= RD;
         grant_q         <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         p0_read_data_o  <= '0;
         p1_read_data_o  <= '0;
         p0_read_done_o  <= 1'b0;
         p0_write_done_o <= 1'b0;
         p1_read_done_o  <= 1'b0;
         p1_write_done_o <= 1'b0;
      end else begin
         p0_read_done_o  <= 1'b0;
         p0_write_done_o <= 1'b0;
         p1_read_done_o  <= 1'b0;
         p1_write_done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_valid_c) begin
                  grant_q <= pick_grant_c;
                  op_q    <= (pick_grant_c ? p1_wr_i : p0_wr_i) ? WR : RD;
                  addr_q  <= pick_grant_c ? p1_address_i : p0_address_i;
                  wdata_q <= pick_grant_c ? p1_write_data_i : p0_write_data_i;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (mem_done_c) begin
                  if (op_q == RD) begin
                     if (grant_q) begin
                        p1_read_data_o <= m_read_data_i;
                        p1_read_done_o <= 1'b1;
                     end else begin
                        p0_read_data_o <= m_read_data_i;
                        p0_read_done_o <= 1'b1;
                     end
                  end else begin
                     if (grant_q) begin
                        p1_write_done_o <= 1'b1;
                     end else begin
                        p0_write_done_o <= 1'b1;
                     end
                  end
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Strobes decode the registered state so they fall as soon as reset asserts.
   assign m_read_o       = (state_q == BUSY) && (op_q == RD) && !m_read_done_i;
   assign m_wr_o         = (state_q == BUSY) && (op_q == WR) && !m_write_done_i;
   assign m_address_o    = addr_q;
   assign m_write_data_o = wdata_q;

   assign p0_busywait_o = reset_ni && req_c[0] && !(state_q == DONE && !grant_q);
   assign p1_busywait_o = reset_ni && req_c[1] && !(state_q == DONE &&  grant_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset and collision sequences.
module tb_mem_arbiter;

   localparam logic [27:0]  A0  = 28'h0000010;
   localparam logic [27:0]  A1  = 28'h0000020;
   localparam logic [127:0] D0  = 128'hDEADBEEF_00000000_00000000_00000001;
   localparam logic [127:0] WD0 = {4{32'h1111_2222}};
   localparam logic [127:0] WD1 = {16{8'hA5}};

   logic         clk_i;
   logic         reset_ni;
   logic         p0_read_i, p0_wr_i, p1_read_i, p1_wr_i;
   logic [27:0]  p0_address_i, p1_address_i;
   logic [127:0] p0_write_data_i, p1_write_data_i;
   logic         p0_busywait_o, p1_busywait_o;
   logic [127:0] p0_read_data_o, p1_read_data_o;
   logic         p0_read_done_o, p0_write_done_o, p1_read_done_o, p1_write_done_o;
   logic         m_read_o, m_wr_o;
   logic [27:0]  m_address_o;
   logic [127:0] m_write_data_o;
   logic         m_busywait_i;
   logic [127:0] m_read_data_i;
   logic         m_read_done_i, m_write_done_i;

   int total = 0;
   int bad   = 0;

   mem_arbiter dut (
      .clk_i           (clk_i),
      .reset_ni        (reset_ni),
      .p0_read_i       (p0_read_i),
      .p0_wr_i         (p0_wr_i),
      .p0_address_i    (p0_address_i),
      .p0_write_data_i (p0_write_data_i),
      .p0_busywait_o   (p0_busywait_o),
      .p0_read_data_o  (p0_read_data_o),
      .p0_read_done_o  (p0_read_done_o),
      .p0_write_done_o (p0_write_done_o),
      .p1_read_i       (p1_read_i),
      .p1_wr_i         (p1_wr_i),
      .p1_address_i    (p1_address_i),
      .p1_write_data_i (p1_write_data_i),
      .p1_busywait_o   (p1_busywait_o),
      .p1_read_data_o  (p1_read_data_o),
      .p1_read_done_o  (p1_read_done_o),
      .p1_write_done_o (p1_write_done_o),
      .m_read_o        (m_read_o),
      .m_wr_o          (m_wr_o),
      .m_address_o     (m_address_o),
      .m_write_data_o  (m_write_data_o),
      .m_busywait_i    (m_busywait_i),
      .m_read_data_i   (m_read_data_i),
      .m_read_done_i   (m_read_done_i),
      .m_write_done_i  (m_write_done_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // One cycle of stimulus and the outputs expected in that same cycle.
   typedef struct {
      logic [3:0]   req;     // {p1_wr, p1_read, p0_wr, p0_read}
      logic [2:0]   mem;     // {m_write_done, m_read_done, m_busywait}
      logic [1:0]   strobe;  // {m_wr, m_read}
      logic [1:0]   busy;    // {p1_busywait, p0_busywait}
      logic [3:0]   done;    // {p1_write_done, p1_read_done, p0_write_done, p0_read_done}
      logic [27:0]  addr;
      logic [127:0] wd;
      logic [127:0] rd0;
      logic [127:0] rd1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] req, input logic [2:0] mem,
                               input logic [1:0] strobe, input logic [1:0] busy,
                               input logic [3:0] done, input logic [27:0] addr,
                               input logic [127:0] wd, input logic [127:0] rd0,
                               input logic [127:0] rd1);
      vec_t v;
      v.req = req; v.mem = mem; v.strobe = strobe; v.busy = busy; v.done = done;
      v.addr = addr; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply(input vec_t v);
      {p1_wr_i, p1_read_i, p0_wr_i, p0_read_i}     = v.req;
      {m_write_done_i, m_read_done_i, m_busywait_i} = v.mem;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog bound expired");
      $fatal(1);
   end

   initial begin
      logic [1:0] win_exp;

      reset_ni = 1'b0;
      {p0_read_i, p0_wr_i, p1_read_i, p1_wr_i} = 4'b0;
      p0_address_i = A0;  p1_address_i = A1;
      p0_write_data_i = WD0;  p1_write_data_i = WD1;
      m_busywait_i = 1'b0;  m_read_done_i = 1'b0;  m_write_done_i = 1'b0;
      m_read_data_i = D0;

      // Reset, then reset again in the middle of a p0 read.
      tick(); tick();
      reset_ni = 1'b1;
      #1;
      chk("reset strobes", {m_wr_o, m_read_o}, 2'b00);
      chk("reset addr", m_address_o, 28'h0);
      p0_read_i = 1'b1;
      tick(); #1;
      chk("busy m_read", m_read_o, 1'b1);
      chk("busy m_address", m_address_o, A0);
      reset_ni = 1'b0;
      #1;
      chk("async rst m_read", m_read_o, 1'b0);
      chk("async rst busywait", {p1_busywait_o, p0_busywait_o}, 2'b00);
      p0_read_i = 1'b0;
      tick();
      reset_ni = 1'b1;
      tick(); #1;
      chk("post rst strobes", {m_wr_o, m_read_o}, 2'b00);
      chk("post rst busywait", {p1_busywait_o, p0_busywait_o}, 2'b00);
      chk("post rst done", {p1_write_done_o, p1_read_done_o, p0_write_done_o, p0_read_done_o}, 4'h0);
      chk("post rst addr", m_address_o, 28'h0);
      chk("post rst wdata", m_write_data_o, 128'h0);
      chk("post rst rd0", p0_read_data_o, 128'h0);
      chk("post rst rd1", p1_read_data_o, 128'h0);

      // p0 read, memory done in 4th BUSY cycle
      vecs.push_back(mk(4'b0001, 3'b000, 2'b00, 2'b01, 4'b0000, 28'h0, 0, 0,  0));
      vecs.push_back(mk(4'b0001, 3'b000, 2'b01, 2'b01, 4'b0000, A0,    0, 0,  0));
      vecs.push_back(mk(4'b0001, 3'b000, 2'b01, 2'b01, 4'b0000, A0,    0, 0,  0));
      vecs.push_back(mk(4'b0001, 3'b000, 2'b01, 2'b01, 4'b0000, A0,    0, 0,  0));
      vecs.push_back(mk(4'b0001, 3'b010, 2'b00, 2'b01, 4'b0000, A0,    0, 0,  0));
      vecs.push_back(mk(4'b0001, 3'b000, 2'b00, 2'b00, 4'b0001, A0,    0, D0, 0));
      vecs.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, A0,    0, D0, 0));
      // p1 write-back
      vecs.push_back(mk(4'b1000, 3'b000, 2'b00, 2'b10, 4'b0000, A0,    0,   D0, 0));
      vecs.push_back(mk(4'b1000, 3'b000, 2'b10, 2'b10, 4'b0000, A1,    WD1, D0, 0));
      vecs.push_back(mk(4'b1000, 3'b100, 2'b00, 2'b10, 4'b0000, A1,    0,   D0, 0));
      vecs.push_back(mk(4'b1000, 3'b000, 2'b00, 2'b00, 4'b1000, A1,    0,   D0, 0));
      vecs.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, A1,    0,   D0, 0));
      // p1 read with memory busywait masking read_done
      vecs.push_back(mk(4'b0100, 3'b000, 2'b00, 2'b10, 4'b0000, A1,    0, D0, 0));
      vecs.push_back(mk(4'b0100, 3'b000, 2'b01, 2'b10, 4'b0000, A1,    0, D0, 0));
      vecs.push_back(mk(4'b0100, 3'b011, 2'b00, 2'b10, 4'b0000, A1,    0, D0, 0));
      vecs.push_back(mk(4'b0100, 3'b011, 2'b00, 2'b10, 4'b0000, A1,    0, D0, 0));
      vecs.push_back(mk(4'b0100, 3'b010, 2'b00, 2'b10, 4'b0000, A1,    0, D0, 0));
      vecs.push_back(mk(4'b0100, 3'b000, 2'b00, 2'b00, 4'b0100, A1,    0, D0, D0));
      vecs.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, A1,    0, D0, D0));
      // p0 read+wr together -> write; requests withdrawn while BUSY
      vecs.push_back(mk(4'b0011, 3'b000, 2'b00, 2'b01, 4'b0000, A1,    0,   D0, D0));
      vecs.push_back(mk(4'b0010, 3'b000, 2'b10, 2'b01, 4'b0000, A0,    WD0, D0, D0));
      vecs.push_back(mk(4'b0000, 3'b100, 2'b00, 2'b00, 4'b0000, A0,    0,   D0, D0));
      vecs.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 4'b0010, A0,    0,   D0, D0));
      vecs.push_back(mk(4'b0000, 3'b000, 2'b00, 2'b00, 4'b0000, A0,    0,   D0, D0));

      for (int i = 0; i < vecs.size(); i++) begin
         tick();
         apply(vecs[i]);
         #1;
         chk($sformatf("v%0d strobe", i), {m_wr_o, m_read_o}, vecs[i].strobe);
         chk($sformatf("v%0d busywait", i), {p1_busywait_o, p0_busywait_o}, vecs[i].busy);
         chk($sformatf("v%0d done", i),
             {p1_write_done_o, p1_read_done_o, p0_write_done_o, p0_read_done_o}, vecs[i].done);
         chk($sformatf("v%0d m_address", i), m_address_o, vecs[i].addr);
         chk($sformatf("v%0d rd0", i), p0_read_data_o, vecs[i].rd0);
         chk($sformatf("v%0d rd1", i), p1_read_data_o, vecs[i].rd1);
         if (vecs[i].strobe[1])
            chk($sformatf("v%0d m_write_data", i), m_write_data_o, vecs[i].wd);
      end

      // Fresh reset so the first collision starts from last_grant = 1.
      reset_ni = 1'b0;
      tick(); tick();
      reset_ni = 1'b1;
      #1;
      chk("rst2 rd0", p0_read_data_o, 128'h0);

`ifdef MEM_ARB_RR_EN
      win_exp = 2'b10;
`else
      win_exp = 2'b11;
`endif
      // Both ports keep requesting reads; each IDLE grant is a collision.
      p0_read_i = 1'b1;
      p1_read_i = 1'b1;
      for (int r = 0; r < 2; r++) begin
         logic w;
         w = win_exp[r];
         tick(); #1;
         chk($sformatf("coll%0d addr", r), m_address_o, w ? A1 : A0);
         chk($sformatf("coll%0d m_read", r), m_read_o, 1'b1);
         chk($sformatf("coll%0d busy wait", r), {p1_busywait_o, p0_busywait_o}, 2'b11);
         m_read_done_i = 1'b1;
         tick();
         m_read_done_i = 1'b0;
         #1;
         chk($sformatf("coll%0d done", r), {p1_read_done_o, p0_read_done_o}, w ? 2'b10 : 2'b01);
         chk($sformatf("coll%0d busywait", r), {p1_busywait_o, p0_busywait_o}, w ? 2'b01 : 2'b10);
         tick(); #1;
         chk($sformatf("coll%0d idle", r), {m_read_o, p1_busywait_o, p0_busywait_o}, 3'b011);
      end
      p0_read_i = 1'b0;
      p1_read_i = 1'b0;
      tick(); #1;
      chk("coll end busywait", {p1_busywait_o, p0_busywait_o}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
